// File: rtl/riscv_mem_access_unit.sv
// MEM stage: one outstanding data-memory transaction with byte-lane steering and load extension.
// Optional misaligned-access trap is enabled by defining RISCV_MEM_MISALIGN_TRAP_EN.
module riscv_mem_access_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       alu_result_in,
  input  logic [31:0]       rs2_data_in,
  input  logic [4:0]        rd_addr_in,
  input  logic [31:0]       pc_plus4_in,
  input  logic [2:0]        funct3_in,
  input  logic              reg_write_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic              mem_to_reg_in,
  input  logic              jump_in,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic [3:0]        dmem_be,
  input  logic              dmem_ready,
  input  logic [31:0]       dmem_rdata,
  output logic              mem_stall,
  output logic [31:0]       wb_result,
  output logic [4:0]        wb_rd_addr,
  output logic              wb_reg_write,
  output logic              misalign,
  output logic              dbg_state
);

  // Handshake: dmem_req stays high with stable addr/we/be/wdata until the cycle
  // dmem_ready is seen high; that cycle carries the read data and ends the transfer.
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t      r_state;
  logic [1:0]  r_addr_lo;
  logic [2:0]  r_funct3;
  logic        w_mem_op;
  logic        w_trap;
  logic [1:0]  w_a;
  logic [31:0] w_wdata;
  logic [3:0]  w_be;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;

  assign w_a      = alu_result_in[1:0];
  assign w_mem_op = mem_read_in | mem_write_in;

`ifdef RISCV_MEM_MISALIGN_TRAP_EN
  logic r_misalign;
  // funct3[1] set means a word-sized access (including the unused encodings).
  assign w_trap   = w_mem_op &&
                    ((funct3_in[1:0] == 2'b01 && w_a[0]) || (funct3_in[1] && w_a != 2'b00));
  assign misalign = r_misalign;
`else
  assign w_trap   = 1'b0;
  assign misalign = 1'b0;
`endif

  assign dbg_state = r_state;

  always_comb begin
    mem_stall = 1'b0;
    case (r_state)
      IDLE: mem_stall = w_mem_op && !w_trap;
      BUSY: mem_stall = !dmem_ready;
      default: mem_stall = 1'b0;
    endcase
  end

  always_comb begin
    w_wdata = rs2_data_in;
    w_be    = 4'b1111;
    case (funct3_in)
      3'b000: begin
        w_wdata = {4{rs2_data_in[7:0]}};
        w_be    = 4'b0001 << w_a;
      end
      3'b001: begin
        w_wdata = {2{rs2_data_in[15:0]}};
        w_be    = w_a[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        w_wdata = rs2_data_in;
        w_be    = 4'b1111;
      end
    endcase
  end

  // Extraction uses the address bits captured at issue, not the live inputs.
  always_comb begin
    case (r_addr_lo)
      2'd0:    w_byte = dmem_rdata[7:0];
      2'd1:    w_byte = dmem_rdata[15:8];
      2'd2:    w_byte = dmem_rdata[23:16];
      default: w_byte = dmem_rdata[31:24];
    endcase
    w_half = r_addr_lo[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (r_funct3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load = {24'd0, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b101:  w_load = {16'd0, w_half};
      default: w_load = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_addr_lo    <= 2'd0;
      r_funct3     <= 3'd0;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_wdata   <= 32'd0;
      dmem_be      <= 4'd0;
      wb_result    <= 32'd0;
      wb_rd_addr   <= 5'd0;
      wb_reg_write <= 1'b0;
`ifdef RISCV_MEM_MISALIGN_TRAP_EN
      r_misalign   <= 1'b0;
`endif
    end else begin
`ifdef RISCV_MEM_MISALIGN_TRAP_EN
      r_misalign <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (w_trap) begin
`ifdef RISCV_MEM_MISALIGN_TRAP_EN
            r_misalign <= 1'b1;
`endif
            wb_result    <= alu_result_in;
            wb_rd_addr   <= rd_addr_in;
            wb_reg_write <= 1'b0;
          end else if (w_mem_op) begin
            // A store takes priority when both read and write are requested.
            dmem_req     <= 1'b1;
            dmem_we      <= mem_write_in;
            dmem_addr    <= {alu_result_in[ADDR_W-1:2], 2'b00};
            dmem_be      <= mem_write_in ? w_be : 4'b1111;
            dmem_wdata   <= mem_write_in ? w_wdata : 32'd0;
            r_addr_lo    <= w_a;
            r_funct3     <= funct3_in;
            wb_reg_write <= 1'b0;
            r_state      <= BUSY;
          end else begin
            wb_result    <= jump_in ? pc_plus4_in : alu_result_in;
            wb_rd_addr   <= rd_addr_in;
            wb_reg_write <= reg_write_in;
          end
        end
        BUSY: begin
          if (dmem_ready) begin
            dmem_req     <= 1'b0;
            wb_result    <= mem_to_reg_in ? w_load : alu_result_in;
            wb_rd_addr   <= rd_addr_in;
            wb_reg_write <= reg_write_in;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_mem_access_unit.sv
// Directed bench for riscv_mem_access_unit: vector table plus hand-written multi-cycle sequences.
module tb_riscv_mem_access_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] alu_result_in, rs2_data_in, pc_plus4_in;
  logic [4:0]  rd_addr_in;
  logic [2:0]  funct3_in;
  logic        reg_write_in, mem_read_in, mem_write_in, mem_to_reg_in, jump_in;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready;
  logic        mem_stall;
  logic [31:0] wb_result;
  logic [4:0]  wb_rd_addr;
  logic        wb_reg_write, misalign, dbg_state;

  int total = 0;
  int bad   = 0;

  riscv_mem_access_unit #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_result_in(alu_result_in), .rs2_data_in(rs2_data_in),
    .rd_addr_in(rd_addr_in), .pc_plus4_in(pc_plus4_in), .funct3_in(funct3_in),
    .reg_write_in(reg_write_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .mem_to_reg_in(mem_to_reg_in), .jump_in(jump_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .mem_stall(mem_stall), .wb_result(wb_result), .wb_rd_addr(wb_rd_addr),
    .wb_reg_write(wb_reg_write), .misalign(misalign), .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] alu, rs2, pc4, rdata;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        rw, mr, mw, m2r, jmp;
    logic [31:0] e_wb;
    logic        e_we;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_be;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [31:0] alu, input logic [31:0] rs2, input logic [31:0] pc4,
                       input logic [4:0] rd, input logic [2:0] f3, input logic rw,
                       input logic mr, input logic mw, input logic m2r, input logic jmp);
    alu_result_in = alu; rs2_data_in = rs2; pc_plus4_in = pc4; rd_addr_in = rd;
    funct3_in = f3; reg_write_in = rw; mem_read_in = mr; mem_write_in = mw;
    mem_to_reg_in = m2r; jump_in = jmp;
  endtask

  task automatic drive_nop();
    drive(32'd0, 32'd0, 32'd0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic vec_t mk(input logic [31:0] alu, input logic [31:0] rs2, input logic [31:0] pc4,
                              input logic [31:0] rdata, input logic [4:0] rd, input logic [2:0] f3,
                              input logic rw, input logic mr, input logic mw, input logic m2r,
                              input logic jmp, input logic [31:0] e_wb, input logic [31:0] e_addr,
                              input logic [31:0] e_wdata, input logic [3:0] e_be);
    vec_t v;
    v.alu = alu; v.rs2 = rs2; v.pc4 = pc4; v.rdata = rdata; v.rd = rd; v.f3 = f3;
    v.rw = rw; v.mr = mr; v.mw = mw; v.m2r = m2r; v.jmp = jmp;
    v.e_wb = e_wb; v.e_we = mw; v.e_addr = e_addr; v.e_wdata = e_wdata; v.e_be = e_be;
    return v;
  endfunction

  initial begin
    // alu rs2 pc4 rdata rd f3 rw mr mw m2r jmp | wb addr wdata be
    vecs.push_back(mk(32'h1234, 0, 0, 0, 5, 3'b000, 1, 0, 0, 0, 0, 32'h1234, 0, 0, 0));
    vecs.push_back(mk(32'hDEAD, 0, 32'h108, 0, 1, 3'b000, 1, 0, 0, 0, 1, 32'h108, 0, 0, 0));
    vecs.push_back(mk(32'h55, 0, 0, 0, 7, 3'b000, 0, 0, 0, 0, 0, 32'h55, 0, 0, 0));
    vecs.push_back(mk(32'h1003, 0, 0, 32'h80FF_FFFF, 10, 3'b000, 1, 1, 0, 1, 0, 32'hFFFF_FF80, 32'h1000, 0, 4'hF));
    vecs.push_back(mk(32'h1003, 0, 0, 32'h80FF_FFFF, 11, 3'b100, 1, 1, 0, 1, 0, 32'h0000_0080, 32'h1000, 0, 4'hF));
    vecs.push_back(mk(32'h1001, 0, 0, 32'h1234_F600, 12, 3'b000, 1, 1, 0, 1, 0, 32'hFFFF_FFF6, 32'h1000, 0, 4'hF));
    vecs.push_back(mk(32'h2002, 0, 0, 32'h8001_1234, 13, 3'b001, 1, 1, 0, 1, 0, 32'hFFFF_8001, 32'h2000, 0, 4'hF));
    vecs.push_back(mk(32'h2000, 0, 0, 32'h8001_F234, 14, 3'b101, 1, 1, 0, 1, 0, 32'h0000_F234, 32'h2000, 0, 4'hF));
    vecs.push_back(mk(32'h2004, 0, 0, 32'hCAFE_BABE, 15, 3'b010, 1, 1, 0, 1, 0, 32'hCAFE_BABE, 32'h2004, 0, 4'hF));
    vecs.push_back(mk(32'h2008, 0, 0, 32'h11, 16, 3'b010, 1, 1, 0, 0, 0, 32'h2008, 32'h2008, 0, 4'hF));
    vecs.push_back(mk(32'h4000_0002, 32'h1234_56AB, 0, 0, 0, 3'b000, 0, 0, 1, 0, 0, 32'h4000_0002, 32'h4000_0000, 32'hABAB_ABAB, 4'b0100));
    vecs.push_back(mk(32'h3, 32'h77, 0, 0, 0, 3'b000, 0, 0, 1, 0, 0, 32'h3, 32'h0, 32'h7777_7777, 4'b1000));
    vecs.push_back(mk(32'h2000, 32'hDEAD_BEEF, 0, 0, 0, 3'b001, 0, 0, 1, 0, 0, 32'h2000, 32'h2000, 32'hBEEF_BEEF, 4'b0011));
    vecs.push_back(mk(32'h100, 32'h0102_0304, 0, 0, 0, 3'b010, 0, 0, 1, 0, 0, 32'h100, 32'h100, 32'h0102_0304, 4'b1111));
    vecs.push_back(mk(32'h1, 32'hAA, 0, 0, 0, 3'b000, 0, 1, 1, 0, 0, 32'h1, 32'h0, 32'hAAAA_AAAA, 4'b0010));

    // Reset state
    rst_n = 1'b0; dmem_ready = 1'b0; dmem_rdata = 32'd0;
    drive_nop();
    repeat (2) @(negedge clk);
    chk("rst_req", {31'd0, dmem_req}, 0);
    chk("rst_we", {31'd0, dmem_we}, 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_wdata", dmem_wdata, 0);
    chk("rst_be", {28'd0, dmem_be}, 0);
    chk("rst_wb_result", wb_result, 0);
    chk("rst_wb_rd", {27'd0, wb_rd_addr}, 0);
    chk("rst_wb_we", {31'd0, wb_reg_write}, 0);
    chk("rst_misalign", {31'd0, misalign}, 0);
    chk("rst_state", {31'd0, dbg_state}, 0);
    rst_n = 1'b1;
    step();

    // Vector table
    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      v = vecs[i];
      drive(v.alu, v.rs2, v.pc4, v.rd, v.f3, v.rw, v.mr, v.mw, v.m2r, v.jmp);
      #1;
      chk($sformatf("v%0d_stall_issue", i), {31'd0, mem_stall}, {31'd0, (v.mr | v.mw)});
      step();
      if (v.mr || v.mw) begin
        chk($sformatf("v%0d_req", i), {31'd0, dmem_req}, 1);
        chk($sformatf("v%0d_we", i), {31'd0, dmem_we}, {31'd0, v.e_we});
        chk($sformatf("v%0d_addr", i), dmem_addr, v.e_addr);
        chk($sformatf("v%0d_be", i), {28'd0, dmem_be}, {28'd0, v.e_be});
        if (v.mw) chk($sformatf("v%0d_wdata", i), dmem_wdata, v.e_wdata);
        chk($sformatf("v%0d_bubble", i), {31'd0, wb_reg_write}, 0);
        dmem_ready = 1'b1; dmem_rdata = v.rdata;
        #1;
        chk($sformatf("v%0d_stall_done", i), {31'd0, mem_stall}, 0);
        step();
        dmem_ready = 1'b0;
        chk($sformatf("v%0d_req_drop", i), {31'd0, dmem_req}, 0);
      end
      chk($sformatf("v%0d_wb_result", i), wb_result, v.e_wb);
      chk($sformatf("v%0d_wb_rd", i), {27'd0, wb_rd_addr}, {27'd0, v.rd});
      chk($sformatf("v%0d_wb_we", i), {31'd0, wb_reg_write}, {31'd0, v.rw});
    end

    // SH upper lane with three wait states
    begin
      int stall_cycles;
      stall_cycles = 0;
      drive(32'h2002, 32'hDEAD_BEEF, 0, 5'd0, 3'b001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      #1;
      if (mem_stall) stall_cycles++;
      step();
      for (int k = 0; k < 3; k++) begin
        if (mem_stall) stall_cycles++;
        chk($sformatf("sh_req_w%0d", k), {31'd0, dmem_req}, 1);
        chk($sformatf("sh_addr_w%0d", k), dmem_addr, 32'h2000);
        chk($sformatf("sh_wdata_w%0d", k), dmem_wdata, 32'hBEEF_BEEF);
        chk($sformatf("sh_be_w%0d", k), {28'd0, dmem_be}, 32'hC);
        chk($sformatf("sh_we_w%0d", k), {31'd0, dmem_we}, 1);
        chk($sformatf("sh_bubble_w%0d", k), {31'd0, wb_reg_write}, 0);
        if (k < 2) step();
      end
      dmem_ready = 1'b1;
      #1;
      if (mem_stall) stall_cycles++;
      chk("sh_stall_cycles", stall_cycles, 4);
      step();
      dmem_ready = 1'b0;
      chk("sh_req_drop", {31'd0, dmem_req}, 0);
      chk("sh_state_idle", {31'd0, dbg_state}, 0);
    end

    // Reset mid-BUSY, then a stray ready
    drive(32'h500, 0, 0, 5'd9, 3'b010, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    chk("mid_req", {31'd0, dmem_req}, 1);
    chk("mid_state", {31'd0, dbg_state}, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", {31'd0, dmem_req}, 0);
    chk("mid_rst_state", {31'd0, dbg_state}, 0);
    drive_nop();
    @(negedge clk);
    rst_n = 1'b1;
    dmem_ready = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    step();
    step();
    dmem_ready = 1'b0;
    chk("stray_req", {31'd0, dmem_req}, 0);
    chk("stray_state", {31'd0, dbg_state}, 0);
    chk("stray_wb_result", wb_result, 0);
    chk("stray_wb_we", {31'd0, wb_reg_write}, 0);

    // LW at 0x3001
    drive(32'h3001, 0, 0, 5'd3, 3'b010, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    #1;
`ifdef RISCV_MEM_MISALIGN_TRAP_EN
    chk("mis_stall", {31'd0, mem_stall}, 0);
    step();
    drive_nop();
    chk("mis_req", {31'd0, dmem_req}, 0);
    chk("mis_flag", {31'd0, misalign}, 1);
    chk("mis_wb_we", {31'd0, wb_reg_write}, 0);
    chk("mis_wb_result", wb_result, 32'h3001);
    chk("mis_wb_rd", {27'd0, wb_rd_addr}, 3);
    step();
    chk("mis_flag_clear", {31'd0, misalign}, 0);
`else
    chk("mis_stall", {31'd0, mem_stall}, 1);
    step();
    chk("mis_req", {31'd0, dmem_req}, 1);
    chk("mis_addr", dmem_addr, 32'h3000);
    chk("mis_be", {28'd0, dmem_be}, 32'hF);
    chk("mis_flag", {31'd0, misalign}, 0);
    dmem_ready = 1'b1; dmem_rdata = 32'h0BAD_F00D;
    step();
    dmem_ready = 1'b0;
    drive_nop();
    chk("mis_wb_result", wb_result, 32'h0BAD_F00D);
    chk("mis_wb_we", {31'd0, wb_reg_write}, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
